// File: rtl/vend_dispense_seq.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense_seq
// Description : Vend dispense sequencer. On an accepted vend request it emits
//               a product-release pulse, then a 50c and/or a 25c coin-eject
//               pulse according to the change owed. Each pulse is followed by
//               a low gap, and the sequence ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_seq #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       vend_req,
    input  logic [1:0] change_code,
    output logic       guffin,
    output logic       halfDollar_out,
    output logic       quarter_out,
    output logic       busy,
    output logic       done
);

    // Phase counter holds "cycles remaining minus one" in the current state,
    // so its width must cover the longer of the two phase lengths.
    localparam int c_max_cycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GUF  = 3'd1,
        S_GAP  = 3'd2,
        S_HALF = 3'd3,
        S_QTR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    // Latched change code; each bit is cleared as its coin pulse starts, so
    // the state after a gap is decided purely by the bits still pending.
    logic [1:0]         r_code;
    logic [1:0]         w_code_next;

    logic r_guffin;
    logic r_half;
    logic r_qtr;
    logic r_busy;
    logic r_done;
    logic w_guffin_next;
    logic w_half_next;
    logic w_qtr_next;
    logic w_busy_next;
    logic w_done_next;

    // Next-state, counter reload and output decode from the next state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_code_next  = r_code;

        case (r_state)
            S_IDLE: begin
                if (vend_req) begin
                    w_state_next = S_GUF;
                    w_cnt_next   = c_pulse_load;
                    w_code_next  = change_code;
                end
            end

            S_GUF, S_HALF, S_QTR: begin
                if (r_cnt == '0) begin
                    w_state_next = S_GAP;
                    w_cnt_next   = c_gap_load;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            S_GAP: begin
                if (r_cnt == '0) begin
                    if (r_code[1]) begin
                        w_state_next   = S_HALF;
                        w_cnt_next     = c_pulse_load;
                        w_code_next[1] = 1'b0;
                    end else if (r_code[0]) begin
                        w_state_next   = S_QTR;
                        w_cnt_next     = c_pulse_load;
                        w_code_next[0] = 1'b0;
                    end else begin
                        w_state_next = S_DONE;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            S_DONE: begin
                // Requests arriving here are dropped, not queued.
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_code_next  = '0;
            end
        endcase

        // Outputs are decoded from the next state and then registered, so
        // each output flop mirrors the state that is live in the same cycle.
        w_guffin_next = (w_state_next == S_GUF);
        w_half_next   = (w_state_next == S_HALF);
        w_qtr_next    = (w_state_next == S_QTR);
        w_busy_next   = (w_state_next != S_IDLE);
        w_done_next   = (w_state_next == S_DONE);
    end

    // State, counter, latched code and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RES) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_code   <= '0;
            r_guffin <= 1'b0;
            r_half   <= 1'b0;
            r_qtr    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_code   <= w_code_next;
            r_guffin <= w_guffin_next;
            r_half   <= w_half_next;
            r_qtr    <= w_qtr_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign guffin         = r_guffin;
    assign halfDollar_out = r_half;
    assign quarter_out    = r_qtr;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_dispense_seq
// Description : Self-checking bench for vend_dispense_seq. Two instances
//               (4/2 and 1/1 pulse/gap) share stimulus and are compared every
//               cycle against a timeline model of the dispense sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_seq;

    logic       CLK;
    logic       RES;
    logic       vend_req;
    logic [1:0] change_code;

    logic guffin0, half0, qtr0, busy0, done0;
    logic guffin1, half1, qtr1, busy1, done1;

    int checks = 0;
    int errors = 0;

    vend_dispense_seq #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut0 (
        .CLK            (CLK),
        .RES            (RES),
        .vend_req       (vend_req),
        .change_code    (change_code),
        .guffin         (guffin0),
        .halfDollar_out (half0),
        .quarter_out    (qtr0),
        .busy           (busy0),
        .done           (done0)
    );

    vend_dispense_seq #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .CLK            (CLK),
        .RES            (RES),
        .vend_req       (vend_req),
        .change_code    (change_code),
        .guffin         (guffin1),
        .halfDollar_out (half1),
        .quarter_out    (qtr1),
        .busy           (busy1),
        .done           (done1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: per instance, whether a sequence is running, how many
    // cycles since the request edge (1 = first cycle after it), and the code.
    int         m_p[2] = '{4, 1};
    int         m_g[2] = '{2, 1};
    bit         m_act[2];
    int         m_t[2];
    logic [1:0] m_code[2];

    function automatic int seq_len(int p, int g, logic [1:0] code);
        return (1 + int'(code[1]) + int'(code[0])) * (p + g) + 1;
    endfunction

    // Expected {guffin, half, quarter, busy, done} at time t in the sequence
    function automatic logic [4:0] model_out(int p, int g, bit act, int t, logic [1:0] code);
        int kinds[3];
        int n;
        int seg;
        int idx;
        int off;
        logic [4:0] r;
        r = 5'b0;
        if (!act) return r;
        n = 0;
        kinds[n] = 0; n = n + 1;
        if (code[1]) begin kinds[n] = 1; n = n + 1; end
        if (code[0]) begin kinds[n] = 2; n = n + 1; end
        seg = p + g;
        r[1] = 1'b1;
        if (t == n * seg + 1) begin
            r[0] = 1'b1;
        end else begin
            idx = (t - 1) / seg;
            off = (t - 1) % seg;
            if (off < p) begin
                case (kinds[idx])
                    0:       r[4] = 1'b1;
                    1:       r[3] = 1'b1;
                    default: r[2] = 1'b1;
                endcase
            end
        end
        return r;
    endfunction

    task automatic model_update(bit vr, logic [1:0] cc, bit rs);
        for (int i = 0; i < 2; i++) begin
            if (!rs) begin
                m_act[i] = 1'b0;
            end else if (m_act[i]) begin
                if (m_t[i] == seq_len(m_p[i], m_g[i], m_code[i])) m_act[i] = 1'b0;
                else m_t[i] = m_t[i] + 1;
            end else if (vr) begin
                m_act[i]  = 1'b1;
                m_t[i]    = 1;
                m_code[i] = cc;
            end
        end
    endtask

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e0;
        logic [4:0] e1;
        e0 = model_out(m_p[0], m_g[0], m_act[0], m_t[0], m_code[0]);
        e1 = model_out(m_p[1], m_g[1], m_act[1], m_t[1], m_code[1]);
        chk("p4g2 guffin", guffin0, e0[4]);
        chk("p4g2 half",   half0,   e0[3]);
        chk("p4g2 qtr",    qtr0,    e0[2]);
        chk("p4g2 busy",   busy0,   e0[1]);
        chk("p4g2 done",   done0,   e0[0]);
        chk("p1g1 guffin", guffin1, e1[4]);
        chk("p1g1 half",   half1,   e1[3]);
        chk("p1g1 qtr",    qtr1,    e1[2]);
        chk("p1g1 busy",   busy1,   e1[1]);
        chk("p1g1 done",   done1,   e1[0]);
    endtask

    // One clock: drive inputs, take the edge, advance model, check at negedge
    task automatic step(bit vr, logic [1:0] cc, bit rs);
        vend_req    = vr;
        change_code = cc;
        RES         = rs;
        @(posedge CLK);
        model_update(vr, cc, rs);
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b1);
    endtask

    int done_at0;
    int done_at1;
    int half_cnt;
    int qtr_cnt;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_t[i]    = 0;
            m_code[i] = 2'd0;
        end
        RES = 1'b0; vend_req = 1'b0; change_code = 2'd0;

        // Reset state, and a request coincident with reset is ignored
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd3, 1'b0);

        // First request after reset release is accepted at once (code 0)
        done_at0 = -1;
        for (int k = 0; k < 22; k++) begin
            step(k == 0, 2'd0, 1'b1);
            if (done0 === 1'b1 && done_at0 < 0) done_at0 = k + 1;
        end
        chk_int("code0 done cycle", done_at0, 7);

        // Code 3: half then quarter, done at 19
        done_at0 = -1; half_cnt = 0; qtr_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(k == 0, 2'd3, 1'b1);
            if (done0 === 1'b1 && done_at0 < 0) done_at0 = k + 1;
            if (half0 === 1'b1) half_cnt++;
            if (qtr0 === 1'b1) qtr_cnt++;
        end
        chk_int("code3 done cycle", done_at0, 19);
        chk_int("code3 half cycles", half_cnt, 4);
        chk_int("code3 qtr cycles", qtr_cnt, 4);

        // Code 1: quarter only, done at 13
        done_at0 = -1; half_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(k == 0, 2'd1, 1'b1);
            if (done0 === 1'b1 && done_at0 < 0) done_at0 = k + 1;
            if (half0 === 1'b1) half_cnt++;
        end
        chk_int("code1 done cycle", done_at0, 13);
        chk_int("code1 half cycles", half_cnt, 0);

        // Code 2, re-requests in 3 and 13, code switched to 1 from cycle 2
        done_at0 = -1; qtr_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(k == 0 || k == 3 || k == 13, (k >= 2) ? 2'd1 : 2'd2, 1'b1);
            if (done0 === 1'b1 && done_at0 < 0) done_at0 = k + 1;
            if (qtr0 === 1'b1) qtr_cnt++;
        end
        chk_int("code2 done cycle", done_at0, 13);
        chk_int("code2 qtr cycles", qtr_cnt, 0);

        // Code 3 with reset in cycle 8, new request in cycle 10
        for (int k = 0; k < 12; k++) begin
            step(k == 0 || k == 10, 2'd3, k != 8);
            if (k == 10) chk("restart guffin cycle 11", guffin0, 1'b1);
        end
        idle(22);

        // Short-phase instance with code 3: done in cycle 7
        done_at1 = -1;
        for (int k = 0; k < 22; k++) begin
            step(k == 0, 2'd3, 1'b1);
            if (done1 === 1'b1 && done_at1 < 0) done_at1 = k + 1;
        end
        chk_int("p1g1 code3 done cycle", done_at1, 7);

        // Randomized requests, codes and occasional resets
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 39) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_dispense_seq.md
VEND_DISPENSE_SEQ -- requirements
Module: vend_dispense_seq

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4, giving the width in clocks of each output pulse (legal range 1 or more).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, giving the low time in clocks after each pulse (legal range 1 or more).
REQ-003 SHALL have port CLK, input, width 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RES, input, width 1, reset; synchronous and active-low.
REQ-005 SHALL have port vend_req, input, width 1, the vend request from the FSM state register; sampled only in IDLE.
REQ-006 SHALL have port change_code, input, width 2, the change owed: 0 = none, 1 = 25c, 2 = 50c, 3 = 75c; sampled with vend_req.
REQ-007 SHALL have port guffin, output, width 1, the product-release pulse.
REQ-008 SHALL have port halfDollar_out, output, width 1, the 50c coin-eject pulse.
REQ-009 SHALL have port quarter_out, output, width 1, the 25c coin-eject pulse.
REQ-010 SHALL have port busy, output, width 1, high while a dispense sequence is in progress.
REQ-011 SHALL have port done, output, width 1, a one-cycle completion pulse.

Function
REQ-012 SHALL implement the states IDLE, GUF, GAP, HALF, QTR and DONE, with a phase counter sized to hold max(PULSE_CYCLES, GAP_CYCLES).
REQ-013 In IDLE with vend_req=1 at edge N, the block SHALL latch change_code, enter GUF, and assert guffin and busy from cycle N+1.
REQ-014 GUF, HALF and QTR SHALL each last exactly PULSE_CYCLES cycles, and the matching output SHALL be high only during that state.
REQ-015 Every pulse state SHALL be followed by GAP for exactly GAP_CYCLES cycles, with guffin, halfDollar_out and quarter_out all low.
REQ-016 Pulse order SHALL be GUF, then HALF if latched change_code[1]=1, then QTR if latched change_code[0]=1.
REQ-017 For 75c, the block SHALL emit one HALF pulse followed by one QTR pulse; it SHALL never emit three QTR pulses.
REQ-018 After the GAP that follows the last pulse, the block SHALL enter DONE for one cycle with done=1 and busy=1, then return to IDLE.
REQ-019 busy SHALL be high from the first GUF cycle through the DONE cycle inclusive, and low in IDLE.
REQ-020 At most one of guffin, halfDollar_out and quarter_out SHALL be high in any cycle.
REQ-021 vend_req in any state other than IDLE, including DONE, SHALL be ignored, and no request SHALL be queued.
REQ-022 Changes on change_code after the capture edge SHALL have no effect on the sequence in progress.
REQ-023 The phase counter SHALL reload on every state entry and SHALL never wrap within a state.
REQ-024 Total sequence length after the request SHALL be (1 + number of coin pulses) × (PULSE_CYCLES + GAP_CYCLES) + 1 cycles, including DONE.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 While RES=0 at a rising edge, the block SHALL enter IDLE, clear the counter and latched code, and drive guffin, halfDollar_out, quarter_out, busy and done to 0 on that edge.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence immediately, with no further pulses and no done pulse.
REQ-028 vend_req coincident with RES=0 SHALL be ignored.
REQ-029 After RES returns high, the first vend_req SHALL be accepted at the next edge.

Verification (PULSE_CYCLES=4, GAP_CYCLES=2, request at edge 0)
REQ-030 The bench SHALL cover: change_code=0 -> guffin high in cycles 1-4, no coin pulses, done high in cycle 7, busy high in cycles 1-7.
REQ-031 The bench SHALL cover: change_code=3 -> guffin in cycles 1-4, halfDollar_out in 7-10, quarter_out in 13-16, done in 19, busy in 1-19.
REQ-032 The bench SHALL cover: change_code=1 -> guffin in 1-4, quarter_out in 7-10, halfDollar_out never high, done in 13.
REQ-033 The bench SHALL cover: change_code=2, with vend_req re-pulsed in cycles 3 and 13 and change_code switched to 1 in cycle 2 -> halfDollar_out in 7-10 only, done in 13, no second sequence.
REQ-034 The bench SHALL cover: change_code=3 with RES=0 in cycle 8 -> all outputs 0 from cycle 9, no quarter_out, no done; a new request in cycle 10 starts guffin in cycle 11.
REQ-035 The bench SHALL cover: PULSE_CYCLES=1, GAP_CYCLES=1, change_code=3 -> guffin in cycle 1, halfDollar_out in 3, quarter_out in 5, done in 7.
